// File: rtl/food_placer.sv
// -----------------------------------------------------------------------------
// food_placer
// Food-box placement engine for the LED-array snake game. On a place request
// it draws random (x,y) candidates, discards those outside the grid, and asks
// the snake body store whether each in-range candidate is occupied. After
// MAX_TRY draws without success it walks the grid in raster order from the
// last candidate, so a search always ends in either done or fail.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   rand_num_x_i/_y_i        free-running random coordinates (sampled in SAMPLE)
//   place_req_i              1-cycle placement request, dropped while busy
//   food_eaten_i             1-cycle pulse, clears food_valid_o
//   occ_req_o/occ_x_o/occ_y_o occupancy query (registered, held until ack)
//   occ_ack_i/occ_hit_i      query answer; hit=1 means the snake owns the cell
//   food_x_o/food_y_o        current food position
//   food_valid_o             food present on the grid
//   busy_o                   placement in progress
//   done_o                   1-cycle pulse, food_* updated in the same cycle
//   fail_o                   1-cycle pulse, every cell is occupied
// -----------------------------------------------------------------------------
module food_placer #(
    parameter int X_W     = 7,
    parameter int Y_W     = 5,
    parameter int GRID_W  = 96,
    parameter int GRID_H  = 32,
    parameter int RESET_X = 32,
    parameter int RESET_Y = 8,
    parameter int MAX_TRY = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [X_W-1:0] rand_num_x_i,
    input  logic [Y_W-1:0] rand_num_y_i,
    input  logic           place_req_i,
    input  logic           food_eaten_i,
    output logic           occ_req_o,
    output logic [X_W-1:0] occ_x_o,
    output logic [Y_W-1:0] occ_y_o,
    input  logic           occ_ack_i,
    input  logic           occ_hit_i,
    output logic [X_W-1:0] food_x_o,
    output logic [Y_W-1:0] food_y_o,
    output logic           food_valid_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           fail_o
);

    localparam int CELLS  = GRID_W * GRID_H;
    localparam int SCAN_W = $clog2(CELLS + 1);
    localparam int TRY_W  = $clog2(MAX_TRY + 1);

    // One extra bit so a grid as wide as the coordinate range still compares.
    localparam logic [X_W:0]        X_LIM   = (X_W + 1)'(GRID_W);
    localparam logic [Y_W:0]        Y_LIM   = (Y_W + 1)'(GRID_H);
    localparam logic [X_W-1:0]      X_LAST  = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0]      Y_LAST  = Y_W'(GRID_H - 1);
    localparam logic [X_W-1:0]      RST_X   = X_W'(RESET_X);
    localparam logic [Y_W-1:0]      RST_Y   = Y_W'(RESET_Y);
    localparam logic [TRY_W-1:0]    TRY_MAX = TRY_W'(MAX_TRY);
    localparam logic [SCAN_W-1:0]   SCAN_END = SCAN_W'(CELLS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_QUERY  = 2'd2,
        ST_SCAN   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [TRY_W-1:0]  try_cnt_q, try_cnt_d;
    logic              scan_mode_q, scan_mode_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [X_W-1:0]    cand_x_q, cand_x_d;
    logic [Y_W-1:0]    cand_y_q, cand_y_d;
    logic              occ_req_q, occ_req_d;
    logic [X_W-1:0]    occ_x_q, occ_x_d;
    logic [Y_W-1:0]    occ_y_q, occ_y_d;
    logic [X_W-1:0]    food_x_q, food_x_d;
    logic [Y_W-1:0]    food_y_q, food_y_d;
    logic              food_valid_q, food_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;

    logic              x_in_s, y_in_s;
    logic [X_W-1:0]    scan_nx_s;
    logic [Y_W-1:0]    scan_ny_s;
    logic [TRY_W-1:0]  try_inc_s;

    // Range check of the current random draw and raster successor of cand.
    always_comb begin
        x_in_s    = ({1'b0, rand_num_x_i} < X_LIM);
        y_in_s    = ({1'b0, rand_num_y_i} < Y_LIM);
        try_inc_s = try_cnt_q + TRY_W'(1);
        if (cand_x_q == X_LAST) begin
            scan_nx_s = {X_W{1'b0}};
            if (cand_y_q == Y_LAST) begin
                scan_ny_s = {Y_W{1'b0}};
            end else begin
                scan_ny_s = cand_y_q + Y_W'(1);
            end
        end else begin
            scan_nx_s = cand_x_q + X_W'(1);
            scan_ny_s = cand_y_q;
        end
    end

    // Next-state and next-output logic of the placement FSM.
    always_comb begin
        state_d      = state_q;
        try_cnt_d    = try_cnt_q;
        scan_mode_d  = scan_mode_q;
        scan_cnt_d   = scan_cnt_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        occ_req_d    = occ_req_q;
        occ_x_d      = occ_x_q;
        occ_y_d      = occ_y_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        fail_d       = 1'b0;

        // Eating is honoured in every state; a done later in this block wins.
        if (food_eaten_i) begin
            food_valid_d = 1'b0;
        end else begin
            food_valid_d = food_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (place_req_i) begin
                    state_d     = ST_SAMPLE;
                    busy_d      = 1'b1;
                    try_cnt_d   = {TRY_W{1'b0}};
                    scan_mode_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SAMPLE: begin
                try_cnt_d = try_inc_s;
                cand_x_d  = rand_num_x_i;
                cand_y_d  = rand_num_y_i;
                if (x_in_s && y_in_s) begin
                    state_d   = ST_QUERY;
                    occ_req_d = 1'b1;
                    occ_x_d   = rand_num_x_i;
                    occ_y_d   = rand_num_y_i;
                end else if (try_inc_s == TRY_MAX) begin
                    // Out-of-range axes restart from 0 so the scan stays on-grid.
                    state_d     = ST_SCAN;
                    scan_mode_d = 1'b1;
                    scan_cnt_d  = {SCAN_W{1'b0}};
                    cand_x_d    = x_in_s ? rand_num_x_i : {X_W{1'b0}};
                    cand_y_d    = y_in_s ? rand_num_y_i : {Y_W{1'b0}};
                end else begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_QUERY: begin
                if (occ_ack_i) begin
                    occ_req_d = 1'b0;
                    if (!occ_hit_i) begin
                        state_d      = ST_IDLE;
                        food_x_d     = cand_x_q;
                        food_y_d     = cand_y_q;
                        food_valid_d = 1'b1;
                        done_d       = 1'b1;
                        busy_d       = 1'b0;
                    end else if (scan_mode_q) begin
                        state_d = ST_SCAN;
                    end else if (try_cnt_q < TRY_MAX) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        state_d     = ST_SCAN;
                        scan_mode_d = 1'b1;
                        scan_cnt_d  = {SCAN_W{1'b0}};
                    end
                end else begin
                    state_d = ST_QUERY;
                end
            end

            ST_SCAN: begin
                // The walk starts one past cand and ends on cand itself,
                // so CELLS queries cover every cell exactly once.
                if (scan_cnt_q == SCAN_END) begin
                    state_d      = ST_IDLE;
                    fail_d       = 1'b1;
                    busy_d       = 1'b0;
                    food_valid_d = 1'b0;
                end else begin
                    state_d    = ST_QUERY;
                    cand_x_d   = scan_nx_s;
                    cand_y_d   = scan_ny_s;
                    occ_req_d  = 1'b1;
                    occ_x_d    = scan_nx_s;
                    occ_y_d    = scan_ny_s;
                    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                end
            end

            default: begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                occ_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            try_cnt_q    <= {TRY_W{1'b0}};
            scan_mode_q  <= 1'b0;
            scan_cnt_q   <= {SCAN_W{1'b0}};
            cand_x_q     <= {X_W{1'b0}};
            cand_y_q     <= {Y_W{1'b0}};
            occ_req_q    <= 1'b0;
            occ_x_q      <= {X_W{1'b0}};
            occ_y_q      <= {Y_W{1'b0}};
            food_x_q     <= RST_X;
            food_y_q     <= RST_Y;
            food_valid_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            try_cnt_q    <= try_cnt_d;
            scan_mode_q  <= scan_mode_d;
            scan_cnt_q   <= scan_cnt_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            occ_req_q    <= occ_req_d;
            occ_x_q      <= occ_x_d;
            occ_y_q      <= occ_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
        end
    end

    assign occ_req_o    = occ_req_q;
    assign occ_x_o      = occ_x_q;
    assign occ_y_o      = occ_y_q;
    assign food_x_o     = food_x_q;
    assign food_y_o     = food_y_q;
    assign food_valid_o = food_valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign fail_o       = fail_q;

endmodule

// File: tb/tb_food_placer.sv
// -----------------------------------------------------------------------------
// tb_food_placer
// Self-checking bench for food_placer with default parameters. A responder
// answers occupancy queries from a bench-side occupancy map with a chosen ack
// delay; a transaction-level model predicts the query sequence and outcome
// from the draw list and the map.
// -----------------------------------------------------------------------------
module tb_food_placer;

    localparam int W     = 96;
    localparam int H     = 32;
    localparam int MAXT  = 15;
    localparam int CELLS = W * H;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] rand_x;
    logic [4:0] rand_y;
    logic       place_req, food_eaten, occ_ack, occ_hit;
    logic       occ_req, food_valid, busy, done, fail;
    logic [6:0] occ_x, food_x;
    logic [4:0] occ_y, food_y;

    food_placer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rand_num_x_i (rand_x),
        .rand_num_y_i (rand_y),
        .place_req_i  (place_req),
        .food_eaten_i (food_eaten),
        .occ_req_o    (occ_req),
        .occ_x_o      (occ_x),
        .occ_y_o      (occ_y),
        .occ_ack_i    (occ_ack),
        .occ_hit_i    (occ_hit),
        .food_x_o     (food_x),
        .food_y_o     (food_y),
        .food_valid_o (food_valid),
        .busy_o       (busy),
        .done_o       (done),
        .fail_o       (fail)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    bit occ_mem [CELLS];
    int dx[$], dy[$];
    int ex[$], ey[$];
    int exp_res, exp_fx, exp_fy;
    int cur_fx = 32, cur_fy = 8;
    int dp;

    typedef struct {
        int rx; int ry; int dly; int exp_lat; int exp_fx; int exp_fy;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
    endtask

    function automatic int draw_x(input int i);
        return (i < dx.size()) ? dx[i] : 127;
    endfunction

    function automatic int draw_y(input int i);
        return (i < dy.size()) ? dy[i] : 31;
    endfunction

    function automatic void clear_map(input bit v);
        foreach (occ_mem[i]) occ_mem[i] = v;
    endfunction

    // Transaction model: queries issued in order, then result 1=done, 2=fail.
    task automatic model_predict();
        int tries, x, y, idx;
        bit to_scan;
        ex.delete(); ey.delete();
        tries = 0; to_scan = 1'b0; x = 0; y = 0;
        while (!to_scan) begin
            x = draw_x(tries); y = draw_y(tries); tries++;
            if (x < W && y < H) begin
                ex.push_back(x); ey.push_back(y);
                if (!occ_mem[y*W + x]) begin
                    exp_res = 1; exp_fx = x; exp_fy = y;
                    return;
                end
                if (tries == MAXT) to_scan = 1'b1;
            end else if (tries == MAXT) begin
                if (x >= W) x = 0;
                if (y >= H) y = 0;
                to_scan = 1'b1;
            end
        end
        idx = y*W + x;
        for (int k = 0; k < CELLS; k++) begin
            idx = (idx + 1) % CELLS;
            ex.push_back(idx % W); ey.push_back(idx / W);
            if (!occ_mem[idx]) begin
                exp_res = 1; exp_fx = idx % W; exp_fy = idx / W;
                return;
            end
        end
        exp_res = 2; exp_fx = cur_fx; exp_fy = cur_fy;
    endtask

    // One placement: request, answer queries, compare against the model.
    task automatic run_place(input string tag, input int dly, input int poke,
                             input int budget, output int lat);
        int nq, qerr, serr, wait_cnt, res, hx, hy;
        nq = 0; qerr = 0; serr = 0; wait_cnt = 0; res = 0; hx = 0; hy = 0;
        lat = -1;
        model_predict();
        dp = 0;
        @(negedge clk);
        place_req = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            place_req = (cyc == poke);
            occ_ack = 1'b0;
            occ_hit = 1'b0;
            if (done || fail) begin
                res = done ? 1 : 2;
                if (done && fail) res = 3;
                lat = cyc;
                break;
            end
            if (occ_req) begin
                if (wait_cnt > 0 && (int'(occ_x) != hx || int'(occ_y) != hy)) serr++;
                hx = int'(occ_x); hy = int'(occ_y);
                if (wait_cnt >= dly) begin
                    occ_ack = 1'b1;
                    occ_hit = (hx < W) ? occ_mem[hy*W + hx] : 1'b1;
                    if (nq >= ex.size() || ex[nq] != hx || ey[nq] != hy) qerr++;
                    nq++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            if (busy && !occ_req) begin
                rand_x = 7'(draw_x(dp));
                rand_y = 5'(draw_y(dp));
                dp++;
            end
        end
        place_req = 1'b0;
        occ_ack = 1'b0;
        chk({tag, " result"}, res, exp_res);
        chk({tag, " query count"}, nq, ex.size());
        chk({tag, " query order errors"}, qerr, 0);
        chk({tag, " occ_x/y stability errors"}, serr, 0);
        chk({tag, " food_x"}, int'(food_x), exp_fx);
        chk({tag, " food_y"}, int'(food_y), exp_fy);
        chk({tag, " food_valid"}, int'(food_valid), (exp_res == 1) ? 1 : 0);
        cur_fx = exp_fx; cur_fy = exp_fy;
    endtask

    initial begin
        int lat, busy_cnt, pulse_cnt, p;
        int pct [4];
        rst_n = 1'b0; place_req = 1'b0; food_eaten = 1'b0;
        occ_ack = 1'b0; occ_hit = 1'b0; rand_x = 7'd0; rand_y = 5'd0;
        pct[0] = 0; pct[1] = 50; pct[2] = 90; pct[3] = 99;

        vecs[0] = '{10, 5, 0, 3, 10, 5};
        vecs[1] = '{0, 0, 1, 4, 0, 0};
        vecs[2] = '{95, 31, 3, 6, 95, 31};
        vecs[3] = '{47, 16, 2, 5, 47, 16};
        vecs[4] = '{63, 0, 0, 3, 63, 0};

        repeat (3) @(negedge clk);
        chk("reset food_x", int'(food_x), 32);
        chk("reset food_y", int'(food_y), 8);
        chk("reset food_valid", int'(food_valid), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset occ_req", int'(occ_req), 0);
        chk("reset occ_x", int'(occ_x), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle done", int'(done), 0);

        // Table: single free draw, varying ack delay, latency = 3 + delay.
        for (int i = 0; i < 5; i++) begin
            clear_map(1'b0);
            dx = '{vecs[i].rx}; dy = '{vecs[i].ry};
            run_place($sformatf("vec%0d", i), vecs[i].dly, 0, 100, lat);
            chk($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d table food_x", i), int'(food_x), vecs[i].exp_fx);
            chk($sformatf("vec%0d table food_y", i), int'(food_y), vecs[i].exp_fy);
        end

        // Out-of-range draws produce no queries.
        clear_map(1'b0);
        dx = '{120, 120, 7}; dy = '{5, 5, 3};
        run_place("oor", 0, 0, 100, lat);
        chk("oor food_x", int'(food_x), 7);
        chk("oor food_y", int'(food_y), 3);

        // Delayed ack with a place_req while busy; no second search may start.
        clear_map(1'b0);
        dx = '{33, 44}; dy = '{12, 13};
        run_place("busyreq", 3, 2, 100, lat);
        busy_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        chk("place_req while busy dropped", busy_cnt, 0);

        // food_eaten in idle clears valid, leaves position.
        @(negedge clk); food_eaten = 1'b1;
        @(negedge clk); food_eaten = 1'b0;
        chk("eaten food_valid", int'(food_valid), 0);
        chk("eaten food_x", int'(food_x), 33);

        // All random candidates hit; raster scan continues from (95,4).
        clear_map(1'b0);
        dx.delete(); dy.delete();
        for (int i = 0; i < 14; i++) begin
            dx.push_back(i*3); dy.push_back(i); occ_mem[i*W + i*3] = 1'b1;
        end
        dx.push_back(95); dy.push_back(4); occ_mem[4*W + 95] = 1'b1;
        run_place("maxtry", 0, 0, 200, lat);
        chk("maxtry food_x", int'(food_x), 0);
        chk("maxtry food_y", int'(food_y), 5);

        // Every cell occupied: full scan then fail.
        clear_map(1'b1);
        dx.delete(); dy.delete();
        run_place("full", 0, 0, 3*CELLS + 100, lat);
        chk("full food_x unchanged", int'(food_x), 0);
        chk("full food_y unchanged", int'(food_y), 5);

        // Reset in the middle of a query.
        clear_map(1'b0);
        dx = '{20}; dy = '{10}; dp = 0;
        @(negedge clk); place_req = 1'b1;
        @(negedge clk); place_req = 1'b0; rand_x = 7'd20; rand_y = 5'd10;
        for (int i = 0; i < 10 && !occ_req; i++) @(negedge clk);
        chk("midreset reached query", int'(occ_req), 1);
        rst_n = 1'b0;
        #1;
        chk("midreset food_x", int'(food_x), 32);
        chk("midreset food_y", int'(food_y), 8);
        chk("midreset food_valid", int'(food_valid), 1);
        chk("midreset busy", int'(busy), 0);
        chk("midreset occ_req", int'(occ_req), 0);
        @(negedge clk); rst_n = 1'b1;
        pulse_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || fail || busy) pulse_cnt++;
        end
        chk("midreset no done/fail", pulse_cnt, 0);
        cur_fx = 32; cur_fy = 8;

        // Randomised placements against the model.
        for (int r = 0; r < 25; r++) begin
            p = pct[$urandom_range(3)];
            foreach (occ_mem[i]) occ_mem[i] = ($urandom_range(99) < p);
            dx.delete(); dy.delete();
            for (int i = 0; i < 20; i++) begin
                dx.push_back($urandom_range(127));
                dy.push_back($urandom_range(31));
            end
            run_place($sformatf("rnd%0d", r), $urandom_range(2), 0, 4*(CELLS + 40) + 50, lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
